// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the pattern scan controller: FSM state encoding,
// default sizing and the pattern-length clamp helper.
// The optional PATTERN_SCAN_MASK_EN build adds a per-bit don't-care mask.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TMO_W   = 16;

    // Lengths beyond the history depth behave as the full depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Bus between the configuring side (master) and the pattern scan
// controller (slave): session control, configuration, serial data and status.
// With PATTERN_SCAN_MASK_EN the bus also carries cfg_mask.
interface pattern_scan_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
);
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;
`ifdef PATTERN_SCAN_MASK_EN
    logic [MAX_LEN-1:0] cfg_mask;
`endif
    logic               datain;
    logic               din_valid;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic               timed_out;
    logic [1:0]         state;

    modport master (
        output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
`ifdef PATTERN_SCAN_MASK_EN
        output cfg_mask,
`endif
        output datain, din_valid,
        input  match_pulse, match_count, busy, done, timed_out, state
    );

    modport slave (
        input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
`ifdef PATTERN_SCAN_MASK_EN
        input  cfg_mask,
`endif
        input  datain, din_valid,
        output match_pulse, match_count, busy, done, timed_out, state
    );

endinterface

// File: rtl/pattern_shift_matcher.sv
// Serial history register, fill counter and pattern compare.
// match is combinational and reflects the history as it will look after the
// bit currently being shifted in, so the controller can register it on the
// same edge that samples the completing bit.
// With PATTERN_SCAN_MASK_EN, mask bits of 0 are excluded from the compare.
module pattern_shift_matcher
    import pattern_scan_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hist_clr,
    input  logic               shift_en,
    input  logic               fill_clr,
    input  logic               din,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
`ifdef PATTERN_SCAN_MASK_EN
    input  logic [MAX_LEN-1:0] mask,
`endif
    output logic               match
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] care;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;

    // Look-ahead view of history and fill including the incoming bit.
    always_comb begin
        hist_nxt = {hist[MAX_LEN-2:0], din};
        fill_inc = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + LEN_W'(1);
    end

    // Select the low len bits as the compared window.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
`ifdef PATTERN_SCAN_MASK_EN
        care = len_mask & mask;
`else
        care = len_mask;
`endif
    end

    assign match = shift_en && (len != '0) && (fill_inc >= len) &&
                   (((hist_nxt ^ pattern) & care) == '0);

    // History shifts in at the LSB; fill restarts on session start or a
    // non-overlapping match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (hist_clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_nxt;
            fill <= fill_clr ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Pattern scan session controller: captures configuration on start, runs the
// serial matcher in SCAN, counts matches and ends the session on target
// count, idle timeout or abort. State encoding: IDLE=0, SCAN=1, DONE=2.
// Optional macro PATTERN_SCAN_MASK_EN enables a captured don't-care mask.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_W   = DEF_TMO_W
) (
    input logic                clk,
    input logic                rst_n,
    pattern_scan_ctrl_if.slave bus
);

    state_t             state_q;
    state_t             state_nxt;

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [TMO_W-1:0]   timeout_q;
`ifdef PATTERN_SCAN_MASK_EN
    logic [MAX_LEN-1:0] mask_q;
`endif

    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_inc;
    logic               timed_out_q;
    logic               match_pulse_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_inc;

    logic               accept;
    logic               scan_live;
    logic               match;
    logic               target_hit;
    logic               timeout_hit;

    // Abort outranks everything, including a start in IDLE and a match in SCAN.
    assign accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign scan_live = (state_q == ST_SCAN) && !bus.abort;

    assign count_inc   = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    assign tmo_inc     = tmo_q + TMO_W'(1);
    assign target_hit  = match && (target_q != '0) && (count_inc == target_q);
    assign timeout_hit = scan_live && (timeout_q != '0) && (tmo_inc == timeout_q);

    pattern_shift_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .rst_n    (rst_n),
        .hist_clr (accept),
        .shift_en (scan_live && bus.din_valid),
        .fill_clr (match && !overlap_q),
        .din      (bus.datain),
        .len      (len_q),
        .pattern  (pattern_q),
`ifdef PATTERN_SCAN_MASK_EN
        .mask     (mask_q),
`endif
        .match    (match)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_nxt = ST_SCAN;
            ST_SCAN: if (target_hit || timeout_hit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.abort) state_nxt = ST_IDLE;
    end

    // State-decoded outputs.
    always_comb begin
        bus.busy  = (state_q == ST_SCAN);
        bus.done  = (state_q == ST_DONE);
        bus.state = state_q;
    end

    // Configuration snapshot taken only when a session is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            timeout_q <= '0;
`ifdef PATTERN_SCAN_MASK_EN
            mask_q    <= '0;
`endif
        end else if (accept) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
            overlap_q <= bus.cfg_overlap;
            target_q  <= bus.cfg_target;
            timeout_q <= bus.cfg_timeout;
`ifdef PATTERN_SCAN_MASK_EN
            mask_q    <= bus.cfg_mask;
`endif
        end
    end

    // Match counting, match pulse, idle-timeout counter and exit cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            timed_out_q   <= 1'b0;
            match_pulse_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            match_pulse_q <= match;
            if (accept) begin
                count_q     <= '0;
                timed_out_q <= 1'b0;
                tmo_q       <= '0;
            end else if (scan_live) begin
                if (match) count_q <= count_inc;
                tmo_q <= match ? '0 : tmo_inc;
                // A reached target takes precedence over a coincident timeout.
                if (target_hit || timeout_hit) timed_out_q <= !target_hit;
            end
        end
    end

    assign bus.match_pulse = match_pulse_q;
    assign bus.match_count = count_q;
    assign bus.timed_out   = timed_out_q;

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Controller that configures, runs and terminates one bit-serial pattern-detection session on a `datain` stream.
- Captures a programmable pattern of up to MAX_LEN bits and selects overlapping or non-overlapping detection.
- Counts matches and ends the session on a target match count, an idle timeout, or an abort.
- Sits between the software/config side and the serial sequence-detector datapath; supersedes the fixed-pattern "101" detectors.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LEN_W, 4: width of cfg_len; must hold MAX_LEN.
- CNT_W, 8: match counter width.
- TMO_W, 16: timeout counter width.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin session; honoured only in IDLE.
- abort, input, 1: terminate session immediately.
- cfg_pattern, input, MAX_LEN: pattern; bit cfg_len-1 is the first-received bit.
- cfg_len, input, LEN_W: pattern length. 0 means never match; values above MAX_LEN are clamped to MAX_LEN.
- cfg_overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- cfg_target, input, CNT_W: matches to finish; 0 = unlimited.
- cfg_timeout, input, TMO_W: cycles without a match before timeout; 0 = disabled.
- datain, input, 1: serial data bit.
- din_valid, input, 1: datain is sampled when high in SCAN.
- match_pulse, output, 1: one-cycle pulse per detected match.
- match_count, output, CNT_W: matches in the current or last session; saturates at all-ones.
- busy, output, 1: high in SCAN.
- done, output, 1: one-cycle pulse on normal completion.
- timed_out, output, 1: sticky; last session ended by timeout.
- state, output, 2: FSM state; IDLE=0, SCAN=1, DONE=2.

Behaviour:
- Reset: all outputs 0, state IDLE, history and fill counter cleared.
- Config capture: all cfg_* inputs are registered when start is accepted in IDLE. Config changes during SCAN have no effect.
- Session start: accepting start also clears match_count, timed_out, history, fill and the timeout counter. SCAN is entered next cycle.
- Sampling: in SCAN with din_valid=1, datain shifts into the LSB of the MAX_LEN history and fill increments, saturating at MAX_LEN.
- Match condition: fill >= len, len != 0, and history[len-1:0] == pattern[len-1:0].
- Match outputs: match_pulse is registered, high the cycle after the completing bit is sampled. match_count increments in that same cycle.
- Non-overlap mode: fill is cleared on a match, so the next match needs len fresh bits.
- Overlap mode: history and fill are kept across a match.
- Timeout counter: increments every SCAN cycle, whether or not din_valid is high. It clears on a match.
- Timeout exit: if cfg_timeout != 0 and the counter equals cfg_timeout, go to DONE with timed_out=1.
- Target exit: if cfg_target != 0 and the count after increment equals cfg_target, go to DONE with timed_out=0.
- Same-cycle match and timeout: the match is counted. If the target is reached, it wins and timed_out=0; otherwise timed_out=1.
- DONE: lasts one cycle with done=1, then IDLE. match_count and timed_out hold until the next start.
- Abort: highest priority in any state; next state is IDLE. No done pulse; match_count holds.
- Start outside IDLE: ignored.
- Start and abort together in IDLE: abort wins.
- Reset mid-session: immediate return to reset values.

Optional Feature:
- Macro: PATTERN_SCAN_MASK_EN.
- With the macro: adds input cfg_mask[MAX_LEN-1:0], captured at start. Bits with mask 0 are don't-care in the compare.
- Without the macro: no port; every bit within len is compared.

Decomposition:
- Shared package pattern_scan_pkg:
  - state encodings IDLE/SCAN/DONE;
  - default MAX_LEN, CNT_W, TMO_W;
  - a clamp-length function.
- Sub-module pattern_shift_matcher:
  - contains the history register, fill counter and compare (mask-aware);
  - inputs: shift enable, fill clear, len, pattern;
  - output: combinational match.
- The controller FSM, counters and timeout logic stay in pattern_scan_ctrl.

Test Plan:
- Non-overlap: pattern=3'b101, len=3, overlap=0, target=0, timeout=0; stream 1,0,1,0,1,0,1 valid every cycle -> match_pulse after bits 3 and 7; match_count=2.
- Overlap: same stream, overlap=1 -> matches after bits 3, 5 and 7; match_count=3.
- Target: overlap=1, target=2 -> done pulse the cycle after the second match, then state IDLE, busy=0, timed_out=0, count=2.
- Timeout: pattern 1111, len=4, timeout=5, stream all 0 -> done with timed_out=1 after 5 SCAN cycles; count=0.
- Abort and gaps: abort mid-stream after 1 match -> IDLE next cycle, no done, count stays 1. din_valid gaps between bits do not break a match.
- Reset and edge configs: rst_n low mid-SCAN -> all outputs 0 immediately. len=0 -> never matches. start while busy is ignored.
